// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that run over WIDTH cycles in the iterative unit.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mc_alu_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one (acc, q) register pair.
module mc_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] opd;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;

    assign last = (cnt == CW'(1));

    // One iteration step: mulu adds the multiplicand when q[0] is set and shifts
    // {acc, q} right; divu shifts {acc, q} left and keeps the trial subtract if
    // it did not underflow (acc < divisor holds, so bit WIDTH flags the sign).
    always_comb begin
        acc_next = acc;
        q_next   = q;
        sum      = '0;
        rem      = '0;
        diff     = '0;
        if (is_div) begin
            rem  = {acc, q[WIDTH-1]};
            diff = rem - {1'b0, opd};
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc} + (q[0] ? {1'b0, opd} : '0);
            acc_next = sum[WIDTH:1];
            q_next   = {sum[0], q[WIDTH-1:1]};
        end
    end

    // Operand capture at accept, then one step per ITER cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            q      <= '0;
            opd    <= '0;
            is_div <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            q      <= is_div_in ? a : b;
            opd    <= is_div_in ? b : a;
            is_div <= is_div_in;
            cnt    <= CW'(WIDTH);
        end else if (step) begin
            acc <= acc_next;
            q   <= q_next;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: start/busy/done handshake, single-cycle logic ops and
// iterative unsigned multiply/divide, with registered results and flags.
module mc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             dbz,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] s_ans;
    logic [WIDTH-1:0] s_hi;
    logic             s_carry;
    logic             s_ovf;
    logic             s_dbz;
    logic             s_ill;
    logic             go_iter;
    logic             iter_load;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] q_next;
    logic             last;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign go_iter   = is_iterative(op) && !((op == OP_DIVU) && (b == '0));
    assign iter_load = (state == IDLE) && start && go_iter;
    assign add_w     = {1'b0, a} + {1'b0, b};
    assign sub_w     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    // Single-cycle results, including the divide-by-zero and illegal shortcuts.
    always_comb begin
        s_ans   = '0;
        s_hi    = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        s_dbz   = 1'b0;
        s_ill   = 1'b0;
        case (op)
            OP_ADD: begin
                s_ans   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_ans   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
                s_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  s_ans = a & b;
            OP_OR:   s_ans = a | b;
            OP_SLT:  s_ans = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MULU: s_ans = '0;
            OP_DIVU: begin
                s_ans = '1;
                s_hi  = a;
                s_dbz = 1'b1;
            end
            default: s_ill = 1'b1;
        endcase
    end

    // Control FSM and output registers; outputs only change when entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ans     <= '0;
            hi      <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (go_iter) begin
                            state <= ITER;
                        end else begin
                            state   <= DONE;
                            ans     <= s_ans;
                            hi      <= s_hi;
                            zero    <= (s_ans == '0);
                            carry   <= s_carry;
                            ovf     <= s_ovf;
                            dbz     <= s_dbz;
                            illegal <= s_ill;
                        end
                    end
                end
                ITER: begin
                    if (last) begin
                        state   <= DONE;
                        ans     <= q_next;
                        hi      <= acc_next;
                        zero    <= (q_next == '0);
                        carry   <= 1'b0;
                        ovf     <= 1'b0;
                        dbz     <= 1'b0;
                        illegal <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mc_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (iter_load),
        .step      (state == ITER),
        .is_div_in (op == OP_DIVU),
        .a         (a),
        .b         (b),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .last      (last)
    );

endmodule

// File: tb/tb_mc_alu.sv
// Randomized self-checking bench for mc_alu (WIDTH=32 and WIDTH=8 instances).
module tb_mc_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a, b, ans, hi;
    logic        zero, carry, ovf, dbz, illegal, busy, done;

    logic        start8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, ans8, hi8;
    logic        zero8, carry8, ovf8, dbz8, illegal8, busy8, done8;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ans;
        logic [31:0] hi;
        logic        zero, carry, ovf, dbz, ill;
        int          lat;
    } exp_t;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ans(ans), .hi(hi), .zero(zero), .carry(carry), .ovf(ovf), .dbz(dbz),
        .illegal(illegal), .busy(busy), .done(done)
    );

    mc_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .ans(ans8), .hi(hi8), .zero(zero8), .carry(carry8), .ovf(ovf8), .dbz(dbz8),
        .illegal(illegal8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour from plain wide arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [63:0] p;
        e.ans = '0; e.hi = '0; e.zero = 0; e.carry = 0; e.ovf = 0; e.dbz = 0; e.ill = 0; e.lat = 0;
        case (o)
            4'b0000: begin
                p = 64'(x) + 64'(y);
                e.ans = p[31:0]; e.carry = p[32];
                e.ovf = (x[31] == y[31]) && (e.ans[31] != x[31]);
            end
            4'b0010: begin
                e.ans = x - y; e.carry = (x >= y);
                e.ovf = (x[31] != y[31]) && (e.ans[31] != x[31]);
            end
            4'b0100: e.ans = x & y;
            4'b0101: e.ans = x | y;
            4'b0111: e.ans = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = 64'(x) * 64'(y);
                e.ans = p[31:0]; e.hi = p[63:32]; e.lat = 32;
            end
            4'b1001: begin
                if (y == 0) begin
                    e.ans = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1;
                end else begin
                    e.ans = x / y; e.hi = x % y; e.lat = 32;
                end
            end
            default: e.ill = 1;
        endcase
        e.zero = (e.ans == 0);
        return e;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
        exp_t e;
        int   lat;
        bit   busy_ok;
        e = model(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        busy_ok = 1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 0;
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(e.lat));
        check("busy_during", 64'(busy_ok), 64'd1);
        check("ans", 64'(ans), 64'(e.ans));
        check("hi", 64'(hi), 64'(e.hi));
        check("flags", {59'd0, zero, carry, ovf, dbz, illegal},
              {59'd0, e.zero, e.carry, e.ovf, e.dbz, e.ill});
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_after", {62'd0, busy, done}, 64'd0);
        check("ans_hold", 64'(ans), 64'(e.ans));
    endtask

    task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp_res);
        int lat;
        @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", 64'(lat), 64'd8);
        check("w8_result", 64'({hi8, ans8}), 64'(exp_res));
        @(posedge clk); #1;
    endtask

    logic [3:0] ops [8] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1111};

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, zero, ans, hi}, 67'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 0);
        run_op(4'b0010, 32'd5, 32'd5, 0);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(4'b1001, 32'd100, 32'd7, 1);
        run_op(4'b1001, 32'd9, 32'd0, 0);

        // Reset during the 10th ITER cycle of a multiply.
        @(negedge clk);
        op = 4'b1000; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_reset", {busy, done, zero, ans, hi}, 67'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 0);

        run_op(4'b1111, 32'hDEAD_BEEF, 32'h1, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            logic [3:0]  o;
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 5) == 0) o = 4'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 0;
                1: y = x;
                2: y = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(o, x, y, 1'($urandom_range(0, 1)));
        end

        run8(4'b1000, 8'hFF, 8'hFF, 16'hFE01);
        run8(4'b1001, 8'd200, 8'd7, {8'd4, 8'd28});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
